// File: rtl/el_dr_sync_capture.sv
`default_nettype none
// ============================================================================
// Module   : el_dr_sync_capture
// Purpose  : Synchronous capture of an elastic dual-rail counter's output bus.
//            Each rail is synchronised into clk. A word is captured once every
//            bit carries the expected phase and the synchronised bus has stayed
//            unchanged for SETTLE_CYC clocks. The captured word is decoded and
//            pushed into a first-word-fall-through FIFO, and the two-phase
//            acknowledge toggles back to the counter.
// Ports    : clk      sole clock
//            rst      asynchronous active-low reset; release is synchronised
//            in       dual-rail word, bit i = {in[2i+1] value, in[2i] parity}
//            ack_o    two-phase acknowledge, one toggle per consumed word
//            data_o   decoded word at the FIFO head (registered)
//            valid_o  data_o is valid (registered)
//            ready_i  consumer accepts data_o
//            level_o  FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module el_dr_sync_capture #(
  parameter int WIDTH       = 32,
  parameter int RAIL_NUM    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RAIL_NUM*WIDTH-1:0] in,
  output logic                      ack_o,
  output logic [WIDTH-1:0]          data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int c_bus_w = RAIL_NUM * WIDTH;
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(SETTLE_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [c_ptr_w:0]   c_depth       = (c_ptr_w + 1)'(DEPTH);

  // Parameter legality checks at elaboration
  if (RAIL_NUM != 2) begin : g_bad_rail_num
    $error("el_dr_sync_capture: RAIL_NUM must be 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("el_dr_sync_capture: SYNC_STAGES must be at least 2");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle_cyc
    $error("el_dr_sync_capture: SETTLE_CYC must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("el_dr_sync_capture: DEPTH must be a power of 2, at least 2");
  end

  // --------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases two clocks after rst rises
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign w_rst_n = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Per-rail synchronisers
  // --------------------------------------------------------------------------
  logic [c_bus_w-1:0] sync_q [SYNC_STAGES];
  logic [c_bus_w-1:0] w_sbus;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign w_sbus = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Decode and completion
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_value;
  logic [WIDTH-1:0] w_phase;
  logic             w_complete;
  logic             exp_ph_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_decode
    assign w_value[i] = w_sbus[2*i+1];
    assign w_phase[i] = w_sbus[2*i] ^ w_sbus[2*i+1];
  end
  // Bits still at the old phase (or regressed to it) make the word incomplete
  assign w_complete = (w_phase == {WIDTH{exp_ph_q}});

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FULL    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_bus_w-1:0] prev_q;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               ack_q;
  logic               w_push;
  logic               w_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    word_d  = word_q;
    w_push  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (w_complete) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!w_complete) begin
          state_d = ST_WAIT;
        end else if (w_sbus != prev_q) begin
          cnt_d = '0;
        end else if (cnt_q == c_settle_last) begin
          // Latch the settled word so a later bus change cannot corrupt it
          state_d = ST_CAPTURE;
          cnt_d   = cnt_q + 1'b1;
          word_d  = w_value;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE, ST_FULL: begin
        // Full is judged on the registered level, so a pop in this cycle
        // only enables the push on the following clock
        if (!w_full) begin
          w_push  = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      prev_q   <= '0;
      word_q   <= '0;
      exp_ph_q <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= w_sbus;
      word_q  <= word_d;
      if (w_push) begin
        ack_q    <= ~ack_q;
        exp_ph_q <= ~exp_ph_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // First-word-fall-through FIFO with registered head
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q, w_rd_ptr_nx;
  logic [c_ptr_w:0]   count_q, count_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q;
  logic               w_pop;

  assign w_full = (count_q == c_depth);
  assign w_pop  = valid_q & ready_i;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
    w_rd_ptr_nx = w_pop ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    // The next head is the entry being written only when it is the sole entry
    data_d = data_q;
    if (count_d != '0) begin
      data_d = (w_push && (wr_ptr_q == w_rd_ptr_nx)) ? word_q : mem_q[w_rd_ptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= word_q;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= w_rd_ptr_nx;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign ack_o   = ack_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign level_o = count_q;

endmodule
`default_nettype wire
